rx_deserializer: RTL and testbench
==================================

# rx_deserializer

Receive-side deserializer of the SERDES link. It consumes the single-bit stream produced by the TX serializer, detects the start bit, and shifts in WIDTH data bits LSB-first plus an optional even-parity bit. It presents each recovered word through a one-entry valid/ready holding register to the downstream RX logic. It sits directly downstream of the TX serializer, on the same clock.

## Interface
- WIDTH, 8: data word width in bits (≥2).
- PARITY_EN, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_en  in  1  receive enable; low forces/holds idle.
- serial_in  in  1  line input; idles at 0.
- data_out  out  WIDTH  recovered word; bit 0 = first data bit received.
- data_valid  out  1  data_out/parity_err hold a word not yet taken.
- data_ready  in  1  consumer accepts word on an edge where data_valid=1.
- parity_err  out  1  parity mismatch for the word in data_out; 0 when PARITY_EN=0.
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- busy  out  1  FSM is in RX_DATA or RX_PARITY.

## Operation
- Reset values: data_out=0, data_valid=0, parity_err=0, overrun=0, busy=0, FSM=RX_IDLE, bit counter=0, shift register=0.
- Frame format: start bit '1', then WIDTH data bits LSB-first, then the parity bit if PARITY_EN=1. Even parity: XOR of data bits XOR parity bit = 0.
- FSM states: RX_IDLE, RX_DATA, RX_PARITY.
  - RX_IDLE→RX_DATA: rx_en=1 and serial_in=1 at an edge. Bit counter is cleared.
  - RX_DATA: samples one bit per cycle into the shift register and increments the counter. After WIDTH samples it moves to RX_PARITY (PARITY_EN=1) or commits and returns to RX_IDLE (PARITY_EN=0).
  - RX_PARITY: samples the parity bit, commits the word, and returns to RX_IDLE.
  - rx_en=0 in any state: next state is RX_IDLE. The partial word is discarded, with no commit and no overrun.
- Commit, on the edge that samples the final bit:
  - If data_valid=0, or data_valid=1 and data_ready=1: load data_out and parity_err; data_valid=1.
  - If data_valid=1 and data_ready=0: the new word is dropped; data_out is unchanged; overrun=1 for one cycle.
- Handshake: data_valid=1 and data_ready=1 with no commit on that edge clears data_valid. data_out keeps its last value.
- The counter is $clog2(WIDTH+1) bits wide. It never wraps, because it is cleared on every start.
- Reset asserted mid-frame: all state returns immediately to reset values, and the partial word is lost.

## Timing
- Start bit sampled at edge t. Data bits are sampled at edges t+1 … t+WIDTH. The parity bit is sampled at edge t+WIDTH+1.
- data_valid rises after edge t+WIDTH+1 with PARITY_EN=1, or after edge t+WIDTH with PARITY_EN=0.
- Back-to-back frames: the FSM is in RX_IDLE the cycle after the final bit. A start bit on that cycle is accepted, so there is zero idle gap.
- busy is high from the cycle after the start edge through the cycle of the final sample.
- overrun is registered and high for exactly the cycle after the dropping commit.
- data_ready has no combinational path to any output.

## Structure
- serdes_pkg holds:
  - typedef enum rx_state_e {RX_IDLE, RX_DATA, RX_PARITY}. The RX_ prefix avoids collision with the TX state names.
  - localparam RX_START_BIT = 1'b1.
- Sub-module rx_holding_reg is natural: the one-entry valid/ready output register with overrun generation.
- The top module keeps the FSM, bit counter, shift register and parity accumulator.

## Test plan
- Basic frame, WIDTH=8, PARITY_EN=1, data_ready=1: send start=1, then bits 1,0,1,0,0,1,0,1, then parity 0. Required: data_valid after edge t+9, data_out=0xA5, parity_err=0, busy high for cycles t+1…t+9.
- Parity error: send 0x3C with parity bit 1. Required: data_out=0x3C, parity_err=1, data_valid=1.
- Overrun: send 0x01 (parity 1) then 0x02 (parity 1) back-to-back with data_ready=0. Required: data_out stays 0x01; overrun pulses for one cycle after the second commit. Then data_ready=1 for one cycle: data_valid=0.
- Abort: drop rx_en at cycle t+4 of a frame. Required: FSM returns to RX_IDLE, no data_valid, no overrun. A following 0xFF frame (parity 0) yields data_out=0xFF, parity_err=0.
- Reset mid-frame: assert rst at cycle t+5 with data_valid=1 from a previous word. Required: all outputs return to 0 asynchronously. The next frame 0x5A (parity 0) is received correctly.
- PARITY_EN=0, back-to-back: frames 0x12 and 0x34 with no gap, data_ready=1. Required: data_valid after edges t+8 and t+17; data_out=0x12 then 0x34; parity_err=0 throughout.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES link receive path.
package serdes_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_e;

  localparam logic RX_START_BIT = 1'b1;

endpackage

// File: rtl/rx_holding_reg.sv
// One-entry valid/ready output register; flags a dropped word with a one-cycle overrun pulse.
module rx_holding_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_data,
  input  logic             commit_perr,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  // Next-state for the holding entry and the overrun pulse
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (commit) begin
      if (!valid_q || data_ready) begin
        data_d  = commit_data;
        perr_d  = commit_perr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      if (valid_q && data_ready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // Holding register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/rx_deserializer.sv
// Receive deserializer: start-bit detect, LSB-first shift-in, optional even parity check.
module rx_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             busy_q, busy_d;
  logic             commit_s;
  logic [WIDTH-1:0] commit_data_s;
  logic             commit_perr_s;

  // Frame FSM, shift register and running parity
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    commit_s      = 1'b0;
    commit_data_s = shift_q;
    commit_perr_s = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_en && (serial_in == RX_START_BIT)) begin
          state_d = RX_DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!rx_en) begin
          state_d = RX_IDLE;
        end else begin
          shift_d = {serial_in, shift_q[WIDTH-1:1]};
          par_d   = par_q ^ serial_in;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            if (PARITY_EN) begin
              state_d = RX_PARITY;
            end else begin
              state_d       = RX_IDLE;
              commit_s      = 1'b1;
              commit_data_s = {serial_in, shift_q[WIDTH-1:1]};
            end
          end else begin
            state_d = RX_DATA;
          end
        end
      end
      RX_PARITY: begin
        if (!rx_en) begin
          state_d = RX_IDLE;
        end else begin
          state_d       = RX_IDLE;
          commit_s      = 1'b1;
          commit_data_s = shift_q;
          commit_perr_s = par_q ^ serial_in;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
    busy_d = (state_d != RX_IDLE);
  end

  // Receive state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  rx_holding_reg #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit_s),
    .commit_data (commit_data_s),
    .commit_perr (commit_perr_s),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_rx_deserializer.sv
// Self-checking bench for rx_deserializer: parity-enabled and parity-disabled instances.
module tb_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       si_p = 1'b0, rdy_p = 1'b1;
  logic       si_n = 1'b0, rdy_n = 1'b1;
  logic [7:0] do_p, do_n;
  logic       dv_p, pe_p, ov_p, bz_p;
  logic       dv_n, pe_n, ov_n, bz_n;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic [7:0] data; logic perr;} exp_t;
  typedef struct {logic [7:0] data; logic pbit; logic perr;} vec_t;

  exp_t qp[$];
  exp_t qn[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  rx_deserializer #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .rx_en(rx_en), .serial_in(si_p),
    .data_out(do_p), .data_valid(dv_p), .data_ready(rdy_p),
    .parity_err(pe_p), .overrun(ov_p), .busy(bz_p)
  );

  rx_deserializer #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .rx_en(rx_en), .serial_in(si_n),
    .data_out(do_n), .data_valid(dv_n), .data_ready(rdy_n),
    .parity_err(pe_n), .overrun(ov_n), .busy(bz_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the parity-enabled instance: pop on every accepted word
  always @(negedge clk) begin
    if (!rst && dv_p && rdy_p) begin
      if (qp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_p_unexpected: got word %0h expected none", do_p);
      end else begin
        exp_t e;
        e = qp.pop_front();
        chk("sb_p_data", 32'(do_p), 32'(e.data));
        chk("sb_p_perr", 32'(pe_p), 32'(e.perr));
      end
    end
  end

  // Scoreboard for the parity-disabled instance
  always @(negedge clk) begin
    if (!rst && dv_n && rdy_n) begin
      if (qn.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_n_unexpected: got word %0h expected none", do_n);
      end else begin
        exp_t e;
        e = qn.pop_front();
        chk("sb_n_data", 32'(do_n), 32'(e.data));
        chk("sb_n_perr", 32'(pe_n), 32'(e.perr));
      end
    end
  end

  task automatic bit_p(input logic b);
    si_p = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_p(input logic [7:0] d, input logic p, input bit tchk);
    bit_p(1'b1);
    if (tchk) chk("p_busy_start", 32'(bz_p), 32'h1);
    for (int i = 0; i < 8; i++) begin
      bit_p(d[i]);
      if (tchk) begin
        chk("p_busy_data", 32'(bz_p), 32'h1);
        chk("p_dv_early", 32'(dv_p), 32'h0);
      end
    end
    bit_p(p);
    si_p = 1'b0;
    if (tchk) begin
      chk("p_busy_end", 32'(bz_p), 32'h0);
      chk("p_dv_t9", 32'(dv_p), 32'h1);
    end
  endtask

  task automatic bit_n(input logic b);
    si_n = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [7:0] d);
    bit_n(1'b1);
    chk("n_dv_start", 32'(dv_n), 32'h0);
    for (int i = 0; i < 8; i++) bit_n(d[i]);
    si_n = 1'b0;
    chk("n_dv_t8", 32'(dv_n), 32'h1);
    chk("n_data", 32'(do_n), 32'(d));
    chk("n_perr", 32'(pe_n), 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1'b1};

    idle(3);
    chk("rst_data", 32'(do_p), 32'h0);
    chk("rst_dv", 32'(dv_p), 32'h0);
    chk("rst_busy", 32'(bz_p), 32'h0);
    chk("rst_ovr", 32'(ov_p), 32'h0);
    rst = 1'b0;
    rx_en = 1'b1;
    idle(2);

    // Basic frame with cycle-accurate busy/valid checks
    qp.push_back('{8'hA5, 1'b0});
    send_p(8'hA5, 1'b0, 1'b1);
    chk("basic_data", 32'(do_p), 32'hA5);
    chk("basic_perr", 32'(pe_p), 32'h0);
    idle(2);

    // Table of frames, sent back-to-back
    for (int i = 0; i < 8; i++) begin
      qp.push_back('{vecs[i].data, vecs[i].perr});
      send_p(vecs[i].data, vecs[i].pbit, 1'b0);
    end
    idle(3);

    // Parity error held with consumer stalled
    rdy_p = 1'b0;
    send_p(8'h3C, 1'b1, 1'b0);
    chk("perr_data", 32'(do_p), 32'h3C);
    chk("perr_flag", 32'(pe_p), 32'h1);
    chk("perr_dv", 32'(dv_p), 32'h1);
    qp.push_back('{8'h3C, 1'b1});
    rdy_p = 1'b1;
    idle(3);

    // Overrun: second word dropped while first is held
    rdy_p = 1'b0;
    qp.push_back('{8'h01, 1'b0});
    send_p(8'h01, 1'b1, 1'b0);
    chk("ovr_first_no_pulse", 32'(ov_p), 32'h0);
    send_p(8'h02, 1'b1, 1'b0);
    chk("ovr_pulse", 32'(ov_p), 32'h1);
    chk("ovr_data_kept", 32'(do_p), 32'h01);
    idle(1);
    chk("ovr_one_cycle", 32'(ov_p), 32'h0);
    chk("ovr_dv_held", 32'(dv_p), 32'h1);
    rdy_p = 1'b1;
    idle(1);
    rdy_p = 1'b0;
    chk("ovr_dv_cleared", 32'(dv_p), 32'h0);
    rdy_p = 1'b1;
    idle(2);

    // Abort mid-frame by dropping rx_en at t+4
    bit_p(1'b1);
    bit_p(1'b1);
    bit_p(1'b1);
    bit_p(1'b1);
    rx_en = 1'b0;
    bit_p(1'b1);
    chk("abort_busy", 32'(bz_p), 32'h0);
    for (int i = 0; i < 3; i++) begin
      bit_p(1'b1);
      chk("abort_dv", 32'(dv_p), 32'h0);
      chk("abort_ovr", 32'(ov_p), 32'h0);
    end
    si_p = 1'b0;
    rx_en = 1'b1;
    idle(1);
    qp.push_back('{8'hFF, 1'b0});
    send_p(8'hFF, 1'b0, 1'b0);
    chk("abort_next_data", 32'(do_p), 32'hFF);
    chk("abort_next_perr", 32'(pe_p), 32'h0);
    idle(2);

    // Reset mid-frame with a held word
    rdy_p = 1'b0;
    send_p(8'h77, 1'b0, 1'b0);
    chk("mrst_pre_dv", 32'(dv_p), 32'h1);
    bit_p(1'b1);
    for (int i = 0; i < 4; i++) bit_p(1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_data", 32'(do_p), 32'h0);
    chk("mrst_dv", 32'(dv_p), 32'h0);
    chk("mrst_busy", 32'(bz_p), 32'h0);
    chk("mrst_perr", 32'(pe_p), 32'h0);
    chk("mrst_ovr", 32'(ov_p), 32'h0);
    si_p = 1'b0;
    idle(1);
    rst = 1'b0;
    rdy_p = 1'b1;
    idle(1);
    qp.push_back('{8'h5A, 1'b0});
    send_p(8'h5A, 1'b0, 1'b0);
    chk("mrst_next_data", 32'(do_p), 32'h5A);
    idle(2);

    // Parity disabled: back-to-back frames, zero gap
    qn.push_back('{8'h12, 1'b0});
    qn.push_back('{8'h34, 1'b0});
    send_n(8'h12);
    send_n(8'h34);
    idle(5);

    chk("sb_p_drained", 32'(qp.size()), 32'h0);
    chk("sb_n_drained", 32'(qn.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
